// File: rtl/pc_gen_ras_if.sv
// Fetch-stage PC generator bus: decoder/pipeline controls in, PC and RAS state out.
// With NPC_RAS_PREDICT_EN defined the bus also carries ras_mispredict.
interface pc_gen_ras_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              flush_valid;
    logic [ADDR_W-1:0] flush_pc;
    logic [1:0]        npc_op;
    logic              branch_taken;
    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] reg1_data;
    logic              is_call;
    logic              is_ret;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] link_addr;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
`ifdef NPC_RAS_PREDICT_EN
    logic              ras_mispredict;

    modport master (
        output stall, flush_valid, flush_pc, npc_op, branch_taken, imm16, imm26,
               reg1_data, is_call, is_ret,
        input  pc, pc_plus4, link_addr, npc, ras_top, ras_empty, ras_full, ras_mispredict
    );
    modport slave (
        input  stall, flush_valid, flush_pc, npc_op, branch_taken, imm16, imm26,
               reg1_data, is_call, is_ret,
        output pc, pc_plus4, link_addr, npc, ras_top, ras_empty, ras_full, ras_mispredict
    );
`else
    modport master (
        output stall, flush_valid, flush_pc, npc_op, branch_taken, imm16, imm26,
               reg1_data, is_call, is_ret,
        input  pc, pc_plus4, link_addr, npc, ras_top, ras_empty, ras_full
    );
    modport slave (
        input  stall, flush_valid, flush_pc, npc_op, branch_taken, imm16, imm26,
               reg1_data, is_call, is_ret,
        output pc, pc_plus4, link_addr, npc, ras_top, ras_empty, ras_full
    );
`endif
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage next-PC generator with a circular return-address stack.
// Define NPC_RAS_PREDICT_EN to predict returns from the RAS and flag mispredicts.
module pc_gen_ras #(
    parameter int          ADDR_W    = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
    input  logic         clk,
    input  logic         rst,
    pc_gen_ras_if.slave  bus
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        OP_SEQ    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_JUMP   = 2'b10,
        OP_REG    = 2'b11
    } npc_op_e;

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic              advance;
    logic              do_pop;
    logic              do_push;
    logic              ras_has;

    assign pc_plus4   = pc_reg + ADDR_W'(4);
    assign branch_off = {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
    assign ras_has    = (cnt_reg != '0);
    assign ras_top    = ras_has ? ras_mem[ptr_reg] : '0;
    assign advance    = !bus.stall && !bus.flush_valid;
    assign do_pop     = bus.is_ret && (npc_op_e'(bus.npc_op) == OP_REG) && ras_has;
    assign do_push    = bus.is_call;

    always_comb begin
        npc = pc_plus4;
        case (npc_op_e'(bus.npc_op))
            OP_SEQ:    npc = pc_plus4;
            OP_BRANCH: npc = bus.branch_taken ? (pc_plus4 + branch_off) : pc_plus4;
            OP_JUMP:   npc = {pc_plus4[ADDR_W-1:28], bus.imm26, 2'b00};
            OP_REG:    npc = bus.reg1_data;
            default:   npc = pc_plus4;
        endcase
`ifdef NPC_RAS_PREDICT_EN
        if (do_pop) begin
            npc = ras_top;
        end
`endif
    end

    // Flush wins over stall; neither lets the RAS move.
    always_comb begin
        pc_next = npc;
        if (bus.flush_valid) begin
            pc_next = bus.flush_pc;
        end else if (bus.stall) begin
            pc_next = pc_reg;
        end
    end

    // jalr $ra (push+pop) rewrites the top in place; a plain push on a full
    // stack lands on the oldest entry because the pointer simply wraps.
    always_comb begin
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        wr_en    = 1'b0;
        wr_idx   = ptr_reg;
        if (advance) begin
            if (do_push && do_pop) begin
                wr_en = 1'b1;
            end else if (do_push) begin
                wr_en    = 1'b1;
                wr_idx   = ptr_reg + PTR_W'(1);
                ptr_next = ptr_reg + PTR_W'(1);
                if (cnt_reg != CNT_W'(RAS_DEPTH)) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end else if (do_pop) begin
                ptr_next = ptr_reg - PTR_W'(1);
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= ADDR_W'(RESET_PC);
            ptr_reg <= '0;
            cnt_reg <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc_reg  <= pc_next;
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
            if (wr_en) begin
                ras_mem[wr_idx] <= pc_plus4;
            end
        end
    end

`ifdef NPC_RAS_PREDICT_EN
    logic mispredict_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_reg <= 1'b0;
        end else begin
            mispredict_reg <= advance && do_pop && (ras_top != bus.reg1_data);
        end
    end

    assign bus.ras_mispredict = mispredict_reg;
`endif

    assign bus.pc        = pc_reg;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.link_addr = pc_plus4;
    assign bus.npc       = npc;
    assign bus.ras_top   = ras_top;
    assign bus.ras_empty = !ras_has;
    assign bus.ras_full  = (cnt_reg == CNT_W'(RAS_DEPTH));
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Fetch-stage program-counter generator: holds the architectural PC register and computes the next PC each cycle.
- Sources: sequential, conditional branch, 26-bit jump, register jump, or pipeline redirect (flush).
- Adds a parametrised circular return-address stack (RAS) that tracks call/return nesting.
- Sits between the instruction memory address port and the decode stage; consumes the decoder's npc op code and the branch comparator result.

Parameters:
- ADDR_W, 32, PC/address width; legal range 32..64.
- RAS_DEPTH, 4, RAS entries; power of two, >= 2.
- RESET_PC, 32'h0000_3000, PC value after reset; zero-extended to ADDR_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and RAS this cycle
- flush_valid  in  1  redirect from a later stage
- flush_pc  in  ADDR_W  redirect target
- npc_op  in  2  00 SEQ, 01 BRANCH, 10 JUMP, 11 REG
- branch_taken  in  1  comparator result; used only for BRANCH
- imm16  in  16  branch offset, in words
- imm26  in  26  jump target field
- reg1_data  in  ADDR_W  rs value for REG
- is_call  in  1  current instruction links (jal/jalr)
- is_ret  in  1  current instruction is a return (jr $ra)
- pc  out  ADDR_W  current PC, registered
- pc_plus4  out  ADDR_W  pc+4, combinational
- link_addr  out  ADDR_W  = pc_plus4; value pushed on call
- npc  out  ADDR_W  next-PC selection, combinational
- ras_top  out  ADDR_W  top-of-stack entry; 0 when empty
- ras_empty  out  1  count == 0
- ras_full  out  1  count == RAS_DEPTH

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, RAS pointer=0, count=0, all entries=0. Outputs then read ras_empty=1, ras_full=0, ras_top=0.
- Combinational npc:
  - SEQ: pc+4.
  - BRANCH, branch_taken=1: pc+4 + sext(imm16)<<2.
  - BRANCH, branch_taken=0: pc+4.
  - JUMP: {pc_plus4[ADDR_W-1:28], imm26, 2'b00}.
  - REG: reg1_data.
- All additions are mod 2^ADDR_W; wrap-around is silent.
- PC update at rising edge, priority flush > stall > normal:
  - flush_valid=1: pc<=flush_pc. Overrides stall. RAS untouched.
  - stall=1 (no flush): pc, RAS and count held.
  - Otherwise: pc<=npc. Latency is one cycle from inputs to pc.
- RAS update, only on cycles with no stall and no flush:
  - Pop: is_ret=1 and npc_op=REG and count>0 gives ptr-1 and count-1. Pop while empty is ignored; ras_empty stays 1.
  - Push: is_call=1 writes link_addr at ptr+1 and sets ptr+1; count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular); ras_full stays 1.
  - Simultaneous pop and push (jalr $ra): top entry replaced by link_addr; ptr and count unchanged. When count=0, behaves as a plain push.
- The pointer wraps modulo RAS_DEPTH.
- ras_top = entry[ptr] when count>0, else 0.

Optional Feature:
- Macro NPC_RAS_PREDICT_EN.
- Defined:
  - When npc_op=REG, is_ret=1 and count>0, npc = ras_top instead of reg1_data.
  - Extra output ras_mispredict (1 bit, registered, reset 0) pulses for one cycle when the popped ras_top != reg1_data.
  - The consuming stage then uses flush to correct.
- Undefined: npc always uses reg1_data for REG; ras_mispredict port is absent; RAS is maintained identically.

Test Plan:
1. Reset then 3 SEQ cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C. Assert rst mid-run -> pc returns to 0x3000 immediately, without waiting for a clock edge.
2. pc=0x3010, BRANCH, imm16=0xFFFE, branch_taken=1 -> next pc=0x300C. Same with branch_taken=0 -> pc=0x3014. pc=0x3010, JUMP, imm26=0x0000C40 -> pc=0x3100.
3. stall=1 and flush_valid=1 with flush_pc=0x4000 -> pc=0x4000, RAS count unchanged. stall alone for 2 cycles -> pc held.
4. RAS_DEPTH=4: five calls at pc 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 -> ras_full=1, ras_top=0x3404. Four returns -> tops 0x3404, 0x3304, 0x3204, 0x3104, then ras_empty=1. Fifth return is ignored.
5. Call at 0x3000, then a cycle with is_call=1 and is_ret=1 at 0x3050 -> count=1, ras_top=0x3054.
6. With NPC_RAS_PREDICT_EN: call at 0x3000, return with reg1_data=0x3008 -> npc=0x3004, ras_mispredict=1 for one cycle. Return with reg1_data=0x3004 -> ras_mispredict stays 0.
